// File: rtl/serial_mag_comp.sv
// Digit-serial magnitude comparator: scans two operands MSB-first, DIGIT bits per
// clock, stopping at the first differing digit; optional two's-complement mode.
module serial_mag_comp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

  int unsigned      sh;
  logic [DIGIT-1:0] dx, dy;
  logic             last;

  // Current digit k sits at bits [WIDTH-1-k*DIGIT -: DIGIT]; shift it down to bit 0.
  always_comb begin
    sh   = WIDTH - DIGIT - DIGIT * 32'(cnt_q);
    dx   = DIGIT'(x_q >> sh);
    dy   = DIGIT'(y_q >> sh);
    last = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          x_d            = x;
          y_d            = y;
          x_d[WIDTH-1]   = x[WIDTH-1] ^ signed_mode;
          y_d[WIDTH-1]   = y[WIDTH-1] ^ signed_mode;
          gt_d           = 1'b0;
          lt_d           = 1'b0;
          eq_d           = 1'b0;
          cnt_d          = '0;
          state_d        = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (dx != dy) begin
          gt_d    = (dx > dy);
          lt_d    = (dx < dy);
          state_d = S_FIN;
        end else if (last) begin
          eq_d    = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_FIN);
    gt   = gt_q;
    lt   = lt_q;
    eq   = eq_q;
  end

endmodule
